// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the IF/MEM memory-port arbiter:
//   - FSM state encodings (ARB_IDLE / ARB_FETCH / ARB_DATA / ARB_RESP)
//   - grant identifiers (GRANT_FETCH / GRANT_DATA)
//   - ARB_ERR_DATA, the word returned to a requester on a watchdog abort
//   - arb_pick(): the IDLE-state arbitration decision
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_FETCH = 2'd1;
    localparam logic [1:0] ARB_DATA  = 2'd2;
    localparam logic [1:0] ARB_RESP  = 2'd3;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;

    // Data normally wins, except when both are pending and data had the last
    // grant: then fetch goes first. This bounds fetch starvation to one data
    // transaction.
    function automatic logic [1:0] arb_pick(input logic if_pending,
                                            input logic d_pending,
                                            input logic last_grant);
        logic [1:0] pick;
        pick = ARB_IDLE;
        if (if_pending && d_pending && (last_grant == GRANT_DATA)) begin
            pick = ARB_FETCH;
        end else if (d_pending) begin
            pick = ARB_DATA;
        end else if (if_pending) begin
            pick = ARB_FETCH;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// ---------------------------------------------------------------------------
// mem_arb_watchdog
// Busy-cycle counter for the memory arbiter. Cleared by start (the edge that
// enters FETCH/DATA), incremented on every cycle without ack, saturating at
// TIMEOUT. expire is raised combinationally in the cycle whose end would
// bring the count to TIMEOUT, so the arbiter leaves the busy state after
// exactly TIMEOUT busy cycles.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   start     clear the counter (transaction granted)
//   ack       memory completion; holds the counter and masks expire
//   expire    abort request to the arbiter FSM
// ---------------------------------------------------------------------------
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt_reg <= '0;
        end else if (!ack && (cnt_reg != CW'(TIMEOUT))) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expire = !ack && (cnt_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one multi-cycle memory port between the instruction-fetch requester
// and the MEM-stage data requester. A 4-state FSM grants one requester at a
// time, holds mem_cs until mem_ack, then pulses the granted requester's ack
// for one cycle with the captured read word (0 for writes).
//
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog that aborts a
// transaction after TIMEOUT busy cycles, returning ARB_ERR_DATA and setting
// the sticky timeout_err flag. Without it, timeout_err is tied to 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request level and address
//   if_rdata/if_ack/if_stall  fetch response, ack pulse, stall level
//   d_ren/d_wen/d_addr/d_wdata  data request levels, address, store data
//   d_rdata/d_ack/d_stall     data response, ack pulse, stall level
//   mem_cs/mem_we/mem_addr/mem_din  memory request (from latched registers)
//   mem_dout/mem_ack          memory response
//   timeout_err               sticky watchdog abort flag
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    output logic                  if_stall,
    input  logic                  d_ren,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  d_stall,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_ack,
    output logic                  timeout_err
);

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic                  last_grant_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  we_reg;
    logic [DATA_WIDTH-1:0] if_rdata_reg;
    logic [DATA_WIDTH-1:0] d_rdata_reg;
    logic                  if_ack_reg;
    logic                  d_ack_reg;

    logic                  d_req;
    logic                  busy;
    logic                  grant_start;
    logic                  expire;
    logic                  finish;
    logic                  abort;
    logic [DATA_WIDTH-1:0] resp_word;

    assign d_req = d_ren | d_wen;
    assign busy  = (state_reg == ARB_FETCH) || (state_reg == ARB_DATA);

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:            state_next = arb_pick(if_req, d_req, last_grant_reg);
            ARB_FETCH, ARB_DATA: if (mem_ack || expire) state_next = ARB_RESP;
            ARB_RESP:            state_next = ARB_IDLE;
            default:             state_next = ARB_IDLE;
        endcase
    end

    assign grant_start = (state_reg == ARB_IDLE) && (state_next != ARB_IDLE);

    // A real mem_ack always takes precedence over a coincident expiry.
    assign finish    = busy && (mem_ack || expire);
    assign abort     = busy && !mem_ack && expire;
    assign resp_word = abort  ? DATA_WIDTH'(ARB_ERR_DATA) :
                       we_reg ? '0 : mem_dout;

    // ---------------------------------------------------------- watchdog
`ifdef ARB_TIMEOUT_EN
    logic timeout_err_reg;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (grant_start),
        .ack    (mem_ack),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_reg <= 1'b0;
        end else if (abort) begin
            timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    // No watchdog: busy states wait for mem_ack indefinitely. TIMEOUT is kept
    // in the expression so the parameter list is identical in both builds.
    assign expire      = 1'b0 && (TIMEOUT != 0);
    assign timeout_err = 1'b0;
`endif

    // -------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ARB_IDLE;
            last_grant_reg <= GRANT_FETCH;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            we_reg         <= 1'b0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
            if_ack_reg     <= 1'b0;
            d_ack_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            if_ack_reg <= 1'b0;
            d_ack_reg  <= 1'b0;

            // Latch the winning request so the memory sees stable values even
            // if the requester's inputs wander while it is stalled.
            if (grant_start) begin
                if (state_next == ARB_DATA) begin
                    addr_reg       <= d_addr;
                    wdata_reg      <= d_wdata;
                    we_reg         <= d_wen;
                    last_grant_reg <= GRANT_DATA;
                end else begin
                    addr_reg       <= if_addr;
                    wdata_reg      <= '0;
                    we_reg         <= 1'b0;
                    last_grant_reg <= GRANT_FETCH;
                end
            end

            if (finish) begin
                if (state_reg == ARB_FETCH) begin
                    if_rdata_reg <= resp_word;
                    if_ack_reg   <= 1'b1;
                end else begin
                    d_rdata_reg  <= resp_word;
                    d_ack_reg    <= 1'b1;
                end
            end
        end
    end

    assign mem_cs   = busy;
    assign mem_we   = busy & we_reg;
    assign mem_addr = addr_reg;
    assign mem_din  = wdata_reg;

    assign if_rdata = if_rdata_reg;
    assign if_ack   = if_ack_reg;
    assign d_rdata  = d_rdata_reg;
    assign d_ack    = d_ack_reg;

    assign if_stall = if_req & ~if_ack_reg;
    assign d_stall  = d_req & ~d_ack_reg;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single multi-cycle memory port between the pipeline's instruction-fetch (IF) requester and data (MEM-stage) requester. A small FSM grants one requester at a time, drives the memory handshake, and returns read data with a one-cycle ack pulse. It also produces per-requester stall levels that the pipeline controller folds into its IF/MEM stage enables.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- TIMEOUT, 255, maximum memory-busy cycles before abort; used only with ARB_TIMEOUT_EN.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  main clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request level; held until if_ack.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_rdata  out  DATA_WIDTH  fetched word; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse.
- if_stall  out  1  equals if_req & ~if_ack.
- d_ren, d_wen  in  1  data read/write request levels; held until d_ack.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse.
- d_stall  out  1  equals (d_ren|d_wen) & ~d_ack.
- mem_cs  out  1  memory select; held until mem_ack.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, sampled at posedge.
- timeout_err  out  1  sticky abort flag.

## Operation
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE arbitration, evaluated on each posedge:
  - d_ren|d_wen and if_req both pending, last_grant=DATA → FETCH.
  - Otherwise a data request → DATA.
  - Otherwise if_req → FETCH.
  - Otherwise stay in IDLE.
- Entering FETCH or DATA:
  - Latch address, wdata and we (we = d_wen) into registers.
  - Update last_grant.
  - mem_* outputs are driven only from these latched registers.
- d_wen and d_ren both high: treated as a write (d_wen wins).
- FETCH/DATA: mem_cs=1 every cycle.
- mem_ack sampled high:
  - Capture mem_dout into the response register.
  - Go to RESP.
  - mem_cs drops in the next cycle.
- RESP:
  - Pulse the granted requester's ack for exactly 1 cycle.
  - rdata = captured word; for writes, rdata = 0.
  - Return to IDLE.
  - The pending request is not re-sampled in RESP. Requesters drop or change their request at the edge ending RESP.
- rdata outputs hold their last value outside ack cycles.
- Reset values, including reset mid-transaction:
  - State = IDLE.
  - mem_cs, mem_we, if_ack, d_ack, timeout_err = 0.
  - mem_addr, mem_din, if_rdata, d_rdata = 0.
  - last_grant = FETCH.
  - An in-flight transaction is abandoned without an ack; memory must tolerate mem_cs dropping.

## Timing
- Minimum latency: request seen at edge 0, mem_cs high in cycle 1, mem_ack high in cycle 1, ack and rdata in cycle 2, IDLE in cycle 3. That is 3 cycles request-to-next-grant.
- Each extra cycle without mem_ack adds one cycle.
- Stall outputs are combinational from the request inputs and the registered ack.
- Back-to-back alternating requesters: a fetch is granted at most one transaction after any data grant. Fetch is never starved.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter clears on entering FETCH/DATA and increments each cycle without mem_ack.
  - When the count reaches TIMEOUT, go to RESP with rdata = 32'hDEADBEEF, and set timeout_err. timeout_err stays set until rst.
- ARB_TIMEOUT_EN undefined:
  - No counter; FETCH/DATA wait indefinitely.
  - timeout_err is tied to 0.

## Structure
- Shared header with the other pipeline defines holds:
  - State encodings ARB_IDLE/ARB_FETCH/ARB_DATA/ARB_RESP.
  - GRANT_FETCH/GRANT_DATA.
  - ARB_ERR_DATA = 32'hDEADBEEF.
- Sub-module mem_arb_watchdog (counter + compare, instantiated only under ARB_TIMEOUT_EN).
  - Inputs: clk, rst, start, ack.
  - Output: expire.

## Test plan
- **Single fetch:** if_req=1, if_addr=0x40; memory acks in the first cycle with 0x2008000A → if_ack pulses in cycle 2 with if_rdata=0x2008000A; mem_we=0 throughout.
- **Write:** d_wen=1, d_addr=0x100, d_wdata=0x55AA; mem_ack after 3 wait cycles → mem_cs high for 4 cycles with mem_we=1, mem_din=0x55AA; d_ack pulses once; if_stall stays 0 if if_req=0.
- **Simultaneous requests from IDLE with last_grant=FETCH:**
  - if_req and d_ren both held → DATA granted first, then FETCH.
  - With both still requesting, the order alternates DATA, FETCH, DATA.
- **Reset mid-op:** rst asserted during DATA wait → next cycle mem_cs=0, state IDLE, no d_ack ever pulses, all outputs 0.
- **ARB_TIMEOUT_EN, TIMEOUT=4, mem_ack never asserted:**
  - After 4 busy cycles, ack pulses with rdata=0xDEADBEEF.
  - timeout_err=1 and stays set until rst.
- **d_ren and d_wen both 1:** performs a write (mem_we=1); d_rdata=0 in the ack cycle.
